aes_sbox_scheduler: RTL and testbench

//  Shares one pipelined masked aes_sbox between two requesters: the round datapath (16-byte state,

---
 rtl/aes_sbox_scheduler.sv | 185 ++++++++++++++++++
 tb/tb_aes_sbox_scheduler.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_sbox_scheduler.sv
// Shares one pipelined masked AES S-box between the round state (16 bytes)
// and the key schedule (4 bytes), streaming one byte per cycle.
module aes_sbox_scheduler #(
    parameter int SHARES   = 2,
    parameter int SBOX_LAT = 4,
    parameter int KEY_PRIO = 1
) (
    input  logic                    ClkxCI,
    input  logic                    RstxRI,
    input  logic                    StReqxSI,
    input  logic [128*SHARES-1:0]   StDataxDI,
    output logic                    StAckxSO,
    output logic                    StDonexSO,
    output logic [128*SHARES-1:0]   StResxDO,
    input  logic                    KeyReqxSI,
    input  logic [32*SHARES-1:0]    KeyDataxDI,
    output logic                    KeyAckxSO,
    output logic                    KeyDonexSO,
    output logic [32*SHARES-1:0]    KeyResxDO,
    output logic [8*SHARES-1:0]     SboxInxDO,
    input  logic [8*SHARES-1:0]     SboxOutxDI,
    output logic                    RndReqxSO
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE_ST,
        ISSUE_KEY
    } state_t;

    state_t                       state_q, state_d;
    logic [3:0]                   cnt_q, cnt_d;
    logic [3:0]                   last_idx;
    logic                         st_busy_q, key_busy_q;
    logic                         last_key_q;
    logic [128*SHARES-1:0]        st_buf_q, st_res_q;
    logic [32*SHARES-1:0]         key_buf_q, key_res_q;
    logic [SBOX_LAT-1:0]          tag_v_q, tag_own_q;
    logic [SBOX_LAT-1:0][3:0]     tag_idx_q;
    logic                         st_done_q, key_done_q;
    logic                         can_grant, st_elig, key_elig;
    logic                         tie, key_win, grant_st, grant_key;
    logic                         issuing, issue_key;
    logic                         ret_v, ret_key, st_last, key_last;
    logic [3:0]                   ret_idx;

    // Arbitration: grant only when idle or on the final byte of the current job
    always_comb begin
        last_idx  = (state_q == ISSUE_KEY) ? 4'd3 : 4'd15;
        can_grant = (state_q == IDLE) || (cnt_q == last_idx);
        st_elig   = StReqxSI && !st_busy_q;
        key_elig  = KeyReqxSI && !key_busy_q;
        tie       = st_elig && key_elig;
        key_win   = (KEY_PRIO != 0) || !last_key_q;
        grant_key = can_grant && key_elig && (!st_elig || key_win);
        grant_st  = can_grant && st_elig && !grant_key;
    end

    // Next-state and byte counter; a new grant overrides the end-of-job return to idle
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (grant_st) begin
            state_d = ISSUE_ST;
            cnt_d   = 4'd0;
        end else if (grant_key) begin
            state_d = ISSUE_KEY;
            cnt_d   = 4'd0;
        end else if (state_q != IDLE) begin
            if (cnt_q == last_idx) begin
                state_d = IDLE;
                cnt_d   = 4'd0;
            end else begin
                cnt_d = cnt_q + 4'd1;
            end
        end
    end

    // Issue path: captured byte cnt of every share, zeros when not issuing
    always_comb begin
        issuing   = (state_q != IDLE);
        issue_key = (state_q == ISSUE_KEY);
        SboxInxDO = '0;
        for (int i = 0; i < SHARES; i++) begin
            if (state_q == ISSUE_ST)
                SboxInxDO[8*i +: 8] = st_buf_q[128*i + 8*cnt_q +: 8];
            else if (state_q == ISSUE_KEY)
                SboxInxDO[8*i +: 8] = key_buf_q[32*i + 8*cnt_q[1:0] +: 8];
        end
    end

    // Retiring tag at the S-box output stage
    always_comb begin
        ret_v    = tag_v_q[SBOX_LAT-1];
        ret_key  = tag_own_q[SBOX_LAT-1];
        ret_idx  = tag_idx_q[SBOX_LAT-1];
        st_last  = ret_v && !ret_key && (ret_idx == 4'd15);
        key_last = ret_v && ret_key && (ret_idx == 4'd3);
    end

    // FSM state register
    always_ff @(posedge ClkxCI or posedge RstxRI) begin
        if (RstxRI) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Job capture, busy flags (released after the Done cycle) and tie history
    always_ff @(posedge ClkxCI or posedge RstxRI) begin
        if (RstxRI) begin
            st_buf_q   <= '0;
            key_buf_q  <= '0;
            st_busy_q  <= 1'b0;
            key_busy_q <= 1'b0;
            last_key_q <= 1'b1;
        end else begin
            if (grant_st) begin
                st_buf_q  <= StDataxDI;
                st_busy_q <= 1'b1;
            end else if (st_done_q) begin
                st_busy_q <= 1'b0;
            end
            if (grant_key) begin
                key_buf_q  <= KeyDataxDI;
                key_busy_q <= 1'b1;
            end else if (key_done_q) begin
                key_busy_q <= 1'b0;
            end
            if (can_grant && tie)
                last_key_q <= grant_key;
        end
    end

    // Tag pipeline mirrors the S-box latency
    always_ff @(posedge ClkxCI or posedge RstxRI) begin
        if (RstxRI) begin
            tag_v_q   <= '0;
            tag_own_q <= '0;
            tag_idx_q <= '0;
        end else begin
            tag_v_q[0]   <= issuing;
            tag_own_q[0] <= issue_key;
            tag_idx_q[0] <= cnt_q;
            for (int k = 1; k < SBOX_LAT; k++) begin
                tag_v_q[k]   <= tag_v_q[k-1];
                tag_own_q[k] <= tag_own_q[k-1];
                tag_idx_q[k] <= tag_idx_q[k-1];
            end
        end
    end

    // Result reassembly per owner, share by share, and Done pulses
    always_ff @(posedge ClkxCI or posedge RstxRI) begin
        if (RstxRI) begin
            st_res_q   <= '0;
            key_res_q  <= '0;
            st_done_q  <= 1'b0;
            key_done_q <= 1'b0;
        end else begin
            st_done_q  <= st_last;
            key_done_q <= key_last;
            if (ret_v) begin
                for (int i = 0; i < SHARES; i++) begin
                    if (ret_key)
                        key_res_q[32*i + 8*ret_idx[1:0] +: 8] <= SboxOutxDI[8*i +: 8];
                    else
                        st_res_q[128*i + 8*ret_idx +: 8] <= SboxOutxDI[8*i +: 8];
                end
            end
        end
    end

    assign StAckxSO   = grant_st;
    assign KeyAckxSO  = grant_key;
    assign StDonexSO  = st_done_q;
    assign KeyDonexSO = key_done_q;
    assign StResxDO   = st_res_q;
    assign KeyResxDO  = key_res_q;
    assign RndReqxSO  = issuing;

endmodule

// File: tb/tb_aes_sbox_scheduler.sv
// Bench for aes_sbox_scheduler: two instances (key priority / round robin),
// each fed by a masked S-box model with 4-cycle latency.
module tb_aes_sbox_scheduler;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst [2];
    logic         st_req [2];
    logic         key_req [2];
    logic [255:0] st_data [2];
    logic [63:0]  key_data [2];
    logic         st_ack [2];
    logic         st_done [2];
    logic         key_ack [2];
    logic         key_done [2];
    logic         rnd [2];
    logic [255:0] st_res [2];
    logic [63:0]  key_res [2];
    logic [15:0]  sbox_in [2];
    logic [15:0]  pipe [2][4];
    logic [7:0]   mask;

    int n_tests = 0;
    int n_fail  = 0;

    int s_ack_n, s_ack_at, k_ack_n, k_ack_at;
    int s_done_n, s_done_at, k_done_n, k_done_at;
    int r_n, r_first, r_last, z_bad;

    aes_sbox_scheduler #(.SHARES(2), .SBOX_LAT(4), .KEY_PRIO(1)) u_dut (
        .ClkxCI(clk), .RstxRI(rst[0]),
        .StReqxSI(st_req[0]), .StDataxDI(st_data[0]),
        .StAckxSO(st_ack[0]), .StDonexSO(st_done[0]), .StResxDO(st_res[0]),
        .KeyReqxSI(key_req[0]), .KeyDataxDI(key_data[0]),
        .KeyAckxSO(key_ack[0]), .KeyDonexSO(key_done[0]), .KeyResxDO(key_res[0]),
        .SboxInxDO(sbox_in[0]), .SboxOutxDI(pipe[0][3]), .RndReqxSO(rnd[0])
    );

    aes_sbox_scheduler #(.SHARES(2), .SBOX_LAT(4), .KEY_PRIO(0)) u_rr (
        .ClkxCI(clk), .RstxRI(rst[1]),
        .StReqxSI(st_req[1]), .StDataxDI(st_data[1]),
        .StAckxSO(st_ack[1]), .StDonexSO(st_done[1]), .StResxDO(st_res[1]),
        .KeyReqxSI(key_req[1]), .KeyDataxDI(key_data[1]),
        .KeyAckxSO(key_ack[1]), .KeyDonexSO(key_done[1]), .KeyResxDO(key_res[1]),
        .SboxInxDO(sbox_in[1]), .SboxOutxDI(pipe[1][3]), .RndReqxSO(rnd[1])
    );

    function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
        logic [7:0] a = a_in;
        logic [7:0] b = b_in;
        logic [7:0] p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = a[7] ? ((a << 1) ^ 8'h1B) : (a << 1);
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] v = 8'h00;
        for (int y = 1; y < 256; y++)
            if (x != 8'h00 && gmul(x, 8'(y)) == 8'h01) v = 8'(y);
        return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]}
                 ^ {v[4:0], v[7:5]} ^ {v[3:0], v[7:4]} ^ 8'h63;
    endfunction

    // Masked S-box model: fresh mask per byte, 4-stage latency
    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            mask = 8'($urandom);
            pipe[d][0] <= {mask, sbox(sbox_in[d][7:0] ^ sbox_in[d][15:8]) ^ mask};
            for (int k = 3; k > 0; k--) pipe[d][k] <= pipe[d][k-1];
        end
    end

    // Runs n cycles on instance d, recording events; drop: 1 on Ack, 2 on Done
    task automatic watch(input int d, input int n, input int drop);
        bit sa, ka, sd, kd;
        s_ack_n = 0; s_ack_at = -1; k_ack_n = 0; k_ack_at = -1;
        s_done_n = 0; s_done_at = -1; k_done_n = 0; k_done_at = -1;
        r_n = 0; r_first = -1; r_last = -1; z_bad = 0;
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            sa = st_ack[d]; ka = key_ack[d]; sd = st_done[d]; kd = key_done[d];
            if (sa) begin s_ack_n++; if (s_ack_at < 0) s_ack_at = c; end
            if (ka) begin k_ack_n++; if (k_ack_at < 0) k_ack_at = c; end
            if (sd) begin s_done_n++; if (s_done_at < 0) s_done_at = c; end
            if (kd) begin k_done_n++; if (k_done_at < 0) k_done_at = c; end
            if (rnd[d]) begin
                r_n++;
                if (r_first < 0) r_first = c;
                r_last = c;
            end else if (sbox_in[d] != 16'h0) begin
                z_bad++;
            end
            @(posedge clk);
            #1;
            if ((drop == 1 && sa) || (drop == 2 && sd)) st_req[d] = 1'b0;
            if ((drop == 1 && ka) || (drop == 2 && kd)) key_req[d] = 1'b0;
        end
    endtask

    task automatic test_reset();
        for (int d = 0; d < 2; d++) begin
            n_tests++;
            if ({st_ack[d], st_done[d], key_ack[d], key_done[d], rnd[d]} !== 5'b0) begin
                n_fail++;
                $display("FAIL reset_ctrl[%0d]: got %b want 00000", d,
                         {st_ack[d], st_done[d], key_ack[d], key_done[d], rnd[d]});
            end
            n_tests++;
            if (st_res[d] !== 256'h0 || key_res[d] !== 64'h0 || sbox_in[d] !== 16'h0) begin
                n_fail++;
                $display("FAIL reset_data[%0d]: got %h %h %h want 0", d,
                         st_res[d], key_res[d], sbox_in[d]);
            end
        end
    endtask

    task automatic check_state(input int d, input string nm);
        logic [7:0] got, want;
        for (int k = 0; k < 16; k++) begin
            got  = st_res[d][8*k +: 8] ^ st_res[d][128+8*k +: 8];
            want = sbox(st_data[d][8*k +: 8] ^ st_data[d][128+8*k +: 8]);
            n_tests++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL %s byte%0d: got %h want %h", nm, k, got, want);
            end
        end
    endtask

    task automatic test_state_job();
        for (int k = 0; k < 16; k++) st_data[0][8*k +: 8] = 8'(k);
        st_data[0][255:128] = '0;
        st_req[0] = 1'b1;
        watch(0, 30, 1);
        n_tests++;
        if (s_ack_at !== 0 || s_done_at !== 21 || s_done_n !== 1) begin
            n_fail++;
            $display("FAIL st_timing: got ack %0d done %0d n %0d want 0 21 1",
                     s_ack_at, s_done_at, s_done_n);
        end
        n_tests++;
        if (r_n !== 16) begin
            n_fail++;
            $display("FAIL st_issue_cycles: got %0d want 16", r_n);
        end
        n_tests++;
        if ((st_res[0][7:0] ^ st_res[0][135:128]) !== 8'h63
            || (st_res[0][15:8] ^ st_res[0][143:136]) !== 8'h7C) begin
            n_fail++;
            $display("FAIL st_bytes01: got %h %h want 63 7c",
                     st_res[0][7:0] ^ st_res[0][135:128],
                     st_res[0][15:8] ^ st_res[0][143:136]);
        end
        check_state(0, "st_res");
    endtask

    task automatic test_key_prio();
        st_data[0]  = {$urandom, $urandom, $urandom, $urandom,
                       $urandom, $urandom, $urandom, $urandom};
        key_data[0] = {$urandom, $urandom};
        st_req[0]  = 1'b1;
        key_req[0] = 1'b1;
        watch(0, 40, 1);
        n_tests++;
        if (k_ack_at !== 0 || s_ack_at !== 4) begin
            n_fail++;
            $display("FAIL prio_acks: got key %0d st %0d want 0 4", k_ack_at, s_ack_at);
        end
        n_tests++;
        if (r_n !== 20 || r_first !== 1 || r_last !== 20) begin
            n_fail++;
            $display("FAIL prio_rnd: got n %0d %0d..%0d want 20 1..20", r_n, r_first, r_last);
        end
        n_tests++;
        if (k_done_at !== 9 || s_done_at !== 25) begin
            n_fail++;
            $display("FAIL prio_done: got key %0d st %0d want 9 25", k_done_at, s_done_at);
        end
        check_state(0, "prio_st");
    endtask

    task automatic test_round_robin();
        bit st_first;
        for (int r = 0; r < 3; r++) begin
            st_first = (r % 2 == 0);
            st_data[1]  = {$urandom, $urandom, $urandom, $urandom,
                           $urandom, $urandom, $urandom, $urandom};
            key_data[1] = {$urandom, $urandom};
            st_req[1]  = 1'b1;
            key_req[1] = 1'b1;
            watch(1, 40, 1);
            n_tests++;
            if (s_ack_at !== (st_first ? 0 : 4) || k_ack_at !== (st_first ? 16 : 0)) begin
                n_fail++;
                $display("FAIL rr_round%0d: got st %0d key %0d want st_first=%0d",
                         r, s_ack_at, k_ack_at, st_first);
            end
            n_tests++;
            if (r_n !== 20 || r_last - r_first + 1 !== 20) begin
                n_fail++;
                $display("FAIL rr_gap%0d: got n %0d span %0d want 20", r, r_n,
                         r_last - r_first + 1);
            end
        end
        check_state(1, "rr_st");
    endtask

    task automatic test_key_mask();
        logic [255:0] st_before;
        logic [31:0]  m, u, got;
        st_before   = st_res[0];
        u           = 32'hFF01_0053;
        m           = $urandom;
        key_data[0] = {m, u ^ m};
        key_req[0]  = 1'b1;
        watch(0, 15, 1);
        got = key_res[0][31:0] ^ key_res[0][63:32];
        n_tests++;
        if (got !== 32'h167C_63ED) begin
            n_fail++;
            $display("FAIL key_sub: got %h want 167c63ed", got);
        end
        n_tests++;
        if (k_done_at !== 9 || s_ack_n !== 0) begin
            n_fail++;
            $display("FAIL key_done: got %0d st_ack %0d want 9 0", k_done_at, s_ack_n);
        end
        n_tests++;
        if (st_res[0] !== st_before) begin
            n_fail++;
            $display("FAIL key_st_kept: got %h want %h", st_res[0], st_before);
        end
    endtask

    task automatic test_req_hold();
        logic [31:0] got;
        key_data[0] = {32'h0, 32'h0302_0100};
        key_req[0]  = 1'b1;
        watch(0, 20, 2);
        n_tests++;
        if (k_ack_n !== 1 || k_done_n !== 1) begin
            n_fail++;
            $display("FAIL hold_acks: got ack %0d done %0d want 1 1", k_ack_n, k_done_n);
        end
        n_tests++;
        if (z_bad !== 0) begin
            n_fail++;
            $display("FAIL hold_zero_in: got %0d nonzero idle cycles want 0", z_bad);
        end
        got = key_res[0][31:0] ^ key_res[0][63:32];
        n_tests++;
        if (got !== 32'h7B77_7C63) begin
            n_fail++;
            $display("FAIL hold_sub: got %h want 7b777c63", got);
        end
    endtask

    task automatic test_reset_mid();
        st_data[0] = {$urandom, $urandom, $urandom, $urandom,
                      $urandom, $urandom, $urandom, $urandom};
        st_req[0] = 1'b1;
        watch(0, 8, 1);
        rst[0] = 1'b1;
        #1;
        n_tests++;
        if ({st_ack[0], st_done[0], key_ack[0], key_done[0], rnd[0]} !== 5'b0
            || sbox_in[0] !== 16'h0) begin
            n_fail++;
            $display("FAIL mid_rst_ctrl: got %b %h want 0",
                     {st_ack[0], st_done[0], key_ack[0], key_done[0], rnd[0]}, sbox_in[0]);
        end
        n_tests++;
        if (st_res[0] !== 256'h0 || key_res[0] !== 64'h0) begin
            n_fail++;
            $display("FAIL mid_rst_res: got %h %h want 0", st_res[0], key_res[0]);
        end
        @(posedge clk);
        #1;
        rst[0] = 1'b0;
        watch(0, 30, 0);
        n_tests++;
        if (s_done_n !== 0 || r_n !== 0) begin
            n_fail++;
            $display("FAIL mid_rst_quiet: got done %0d issue %0d want 0 0", s_done_n, r_n);
        end
        st_data[0] = {$urandom, $urandom, $urandom, $urandom,
                      $urandom, $urandom, $urandom, $urandom};
        st_req[0] = 1'b1;
        watch(0, 30, 1);
        n_tests++;
        if (s_ack_at !== 0 || s_done_at !== 21) begin
            n_fail++;
            $display("FAIL mid_rst_rerun: got ack %0d done %0d want 0 21", s_ack_at, s_done_at);
        end
        check_state(0, "rerun_st");
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            rst[d] = 1'b1;
            st_req[d] = 1'b0;
            key_req[d] = 1'b0;
            st_data[d] = '0;
            key_data[d] = '0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        test_reset();
        @(posedge clk);
        #1;
        rst[0] = 1'b0;
        rst[1] = 1'b0;
        test_state_job();
        test_key_prio();
        test_round_robin();
        test_key_mask();
        test_req_hold();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
